// File: rtl/cpu_defs.sv
// Shared definitions for the 8-bit computer: ALU op codes, bus select codes,
// condition-code bit positions and register-file slot indices.
package cpu_defs;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SUB  = 3'b001,
    ALU_AND  = 3'b010,
    ALU_OR   = 3'b011,
    ALU_INC  = 3'b100,
    ALU_DEC  = 3'b101,
    ALU_NOP6 = 3'b110,
    ALU_NOP7 = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    BUS1_PC   = 2'b00,
    BUS1_A    = 2'b01,
    BUS1_B    = 2'b10,
    BUS1_ZERO = 2'b11
  } bus1_sel_e;

  typedef enum logic [1:0] {
    BUS2_ALU  = 2'b00,
    BUS2_BUS1 = 2'b01,
    BUS2_MEM  = 2'b10,
    BUS2_ZERO = 2'b11
  } bus2_sel_e;

  localparam int CCR_N = 3;
  localparam int CCR_Z = 2;
  localparam int CCR_V = 1;
  localparam int CCR_C = 0;

  // Slots of the Bus2-loaded register file inside data_path.
  localparam int REG_IR  = 0;
  localparam int REG_MAR = 1;
  localparam int REG_A   = 2;
  localparam int REG_B   = 3;
  localparam int NUM_REGS = 4;

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU: X comes from Bus1, Y from the B register.
// Produces the result and its NZVC flags.
module alu
  import cpu_defs::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [2:0]       ALU_Sel,
  output logic [WIDTH-1:0] Result,
  output logic [3:0]       NZVC
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_next;
  logic [WIDTH-1:0] result_next;
  logic             v_next;
  logic             c_next;
  logic             flags_en_next;

  always_comb begin
    sum_next      = '0;
    result_next   = '0;
    v_next        = 1'b0;
    c_next        = 1'b0;
    flags_en_next = 1'b1;
    case (alu_op_e'(ALU_Sel))
      ALU_ADD: begin
        sum_next    = {1'b0, X} + {1'b0, Y};
        result_next = sum_next[WIDTH-1:0];
        c_next      = sum_next[WIDTH];
        v_next      = (X[MSB] == Y[MSB]) && (result_next[MSB] != X[MSB]);
      end
      ALU_SUB: begin
        // Two's-complement subtract; carry-out of 0 means a borrow occurred.
        sum_next    = {1'b0, X} + {1'b0, ~Y} + (WIDTH+1)'(1);
        result_next = sum_next[WIDTH-1:0];
        c_next      = ~sum_next[WIDTH];
        v_next      = (X[MSB] != Y[MSB]) && (result_next[MSB] != X[MSB]);
      end
      ALU_AND: result_next = X & Y;
      ALU_OR:  result_next = X | Y;
      ALU_INC: begin
        result_next = X + WIDTH'(1);
        c_next      = &X;
        v_next      = (X == {1'b0, {(WIDTH-1){1'b1}}});
      end
      ALU_DEC: begin
        result_next = X - WIDTH'(1);
        c_next      = ~|X;
        v_next      = (X == {1'b1, {(WIDTH-1){1'b0}}});
      end
      default: flags_en_next = 1'b0;
    endcase
  end

  // Unused op codes force every flag low, including Z.
  always_comb begin
    NZVC = 4'b0000;
    if (flags_en_next) begin
      NZVC[CCR_N] = result_next[MSB];
      NZVC[CCR_Z] = (result_next == '0);
      NZVC[CCR_V] = v_next;
      NZVC[CCR_C] = c_next;
    end
  end

  assign Result = result_next;

endmodule

// File: rtl/data_path.sv
// Register/bus datapath: IR, MAR, PC, A, B, CCR with Bus1/Bus2 muxes and the ALU,
// executing the load/select strobes issued by control_unit.
module data_path
  import cpu_defs::*;
#(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] PC_RESET = 8'h00
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             IR_Load,
  input  logic             MAR_Load,
  input  logic             PC_Load,
  input  logic             PC_Inc,
  input  logic             A_Load,
  input  logic             B_Load,
  input  logic             CCR_Load,
  input  logic [2:0]       ALU_Sel,
  input  logic [1:0]       Bus1_Sel,
  input  logic [1:0]       Bus2_Sel,
  input  logic [WIDTH-1:0] from_memory,
  output logic [WIDTH-1:0] IR,
  output logic [3:0]       CCR_Result,
  output logic [WIDTH-1:0] address,
  output logic [WIDTH-1:0] to_memory
);

  logic [WIDTH-1:0] reg_file_reg [NUM_REGS];
  logic [WIDTH-1:0] pc_reg;
  logic [3:0]       ccr_reg;

  logic [WIDTH-1:0] bus1;
  logic [WIDTH-1:0] bus2;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_nzvc;
  logic [NUM_REGS-1:0] load_vec;

  assign load_vec[REG_IR]  = IR_Load;
  assign load_vec[REG_MAR] = MAR_Load;
  assign load_vec[REG_A]   = A_Load;
  assign load_vec[REG_B]   = B_Load;

  always_comb begin
    bus1 = '0;
    case (bus1_sel_e'(Bus1_Sel))
      BUS1_PC:   bus1 = pc_reg;
      BUS1_A:    bus1 = reg_file_reg[REG_A];
      BUS1_B:    bus1 = reg_file_reg[REG_B];
      default:   bus1 = '0;
    endcase
  end

  always_comb begin
    bus2 = '0;
    case (bus2_sel_e'(Bus2_Sel))
      BUS2_ALU:  bus2 = alu_result;
      BUS2_BUS1: bus2 = bus1;
      BUS2_MEM:  bus2 = from_memory;
      default:   bus2 = '0;
    endcase
  end

  alu #(.WIDTH(WIDTH)) u_alu (
    .X       (bus1),
    .Y       (reg_file_reg[REG_B]),
    .ALU_Sel (ALU_Sel),
    .Result  (alu_result),
    .NZVC    (alu_nzvc)
  );

  // IR, MAR, A and B share one shape: clear on reset, capture Bus2 on their strobe.
  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bus2_regs
      always_ff @(posedge Clk) begin
        if (Reset) begin
          reg_file_reg[gi] <= '0;
        end else if (load_vec[gi]) begin
          reg_file_reg[gi] <= bus2;
        end
      end
    end
  endgenerate

  // A branch load takes precedence over the sequential increment.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_reg <= PC_RESET;
    end else if (PC_Load) begin
      pc_reg <= bus2;
    end else if (PC_Inc) begin
      pc_reg <= pc_reg + WIDTH'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ccr_reg <= 4'b0000;
    end else if (CCR_Load) begin
      ccr_reg <= alu_nzvc;
    end
  end

  assign IR         = reg_file_reg[REG_IR];
  assign address    = reg_file_reg[REG_MAR];
  assign CCR_Result = ccr_reg;
  assign to_memory  = bus1;

endmodule

// File: tb/tb_data_path.sv
// Directed-vector bench for data_path: each task drives one scenario and checks
// hand-computed results; internal registers are observed through Bus1 on to_memory.
module tb_data_path;
  import cpu_defs::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       IR_Load, MAR_Load, PC_Load, PC_Inc, A_Load, B_Load, CCR_Load;
  logic [2:0] ALU_Sel;
  logic [1:0] Bus1_Sel, Bus2_Sel;
  logic [7:0] from_memory;
  logic [7:0] IR;
  logic [3:0] CCR_Result;
  logic [7:0] address;
  logic [7:0] to_memory;

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  data_path #(.WIDTH(8), .PC_RESET(8'h00)) dut (
    .Clk(Clk), .Reset(Reset),
    .IR_Load(IR_Load), .MAR_Load(MAR_Load), .PC_Load(PC_Load), .PC_Inc(PC_Inc),
    .A_Load(A_Load), .B_Load(B_Load), .CCR_Load(CCR_Load),
    .ALU_Sel(ALU_Sel), .Bus1_Sel(Bus1_Sel), .Bus2_Sel(Bus2_Sel),
    .from_memory(from_memory),
    .IR(IR), .CCR_Result(CCR_Result), .address(address), .to_memory(to_memory)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_ctrl();
    Reset = 1'b0; IR_Load = 1'b0; MAR_Load = 1'b0; PC_Load = 1'b0; PC_Inc = 1'b0;
    A_Load = 1'b0; B_Load = 1'b0; CCR_Load = 1'b0;
    ALU_Sel = 3'b000; Bus1_Sel = 2'b00; Bus2_Sel = 2'b00; from_memory = 8'h00;
  endtask

  // Stimulus helpers: put a value into A, B or PC straight from memory.
  task automatic set_a(input logic [7:0] v);
    clear_ctrl(); Bus2_Sel = BUS2_MEM; from_memory = v; A_Load = 1'b1;
    tick(); clear_ctrl();
  endtask

  task automatic set_b(input logic [7:0] v);
    clear_ctrl(); Bus2_Sel = BUS2_MEM; from_memory = v; B_Load = 1'b1;
    tick(); clear_ctrl();
  endtask

  task automatic set_pc(input logic [7:0] v);
    clear_ctrl(); Bus2_Sel = BUS2_MEM; from_memory = v; PC_Load = 1'b1;
    tick(); clear_ctrl();
  endtask

  // Execute one ALU op on A,B writing A (and optionally CCR), then report A and CCR.
  task automatic alu_exec(input logic [2:0] op, input logic ccr_en, input string name,
                          input logic [7:0] exp_a, input logic [3:0] exp_ccr);
    clear_ctrl();
    ALU_Sel = op; Bus1_Sel = BUS1_A; Bus2_Sel = BUS2_ALU; A_Load = 1'b1; CCR_Load = ccr_en;
    tick(); clear_ctrl();
    Bus1_Sel = BUS1_A; #1;
    n_cmp++;
    if (to_memory !== exp_a) begin
      n_err++; $display("FAIL %s A: got %h expected %h", name, to_memory, exp_a);
    end
    n_cmp++;
    if (CCR_Result !== exp_ccr) begin
      n_err++; $display("FAIL %s CCR: got %b expected %b", name, CCR_Result, exp_ccr);
    end
    $display("txn %s op=%b A=%h CCR=%b", name, op, to_memory, CCR_Result);
  endtask

  task automatic test_reset();
    clear_ctrl(); Reset = 1'b1; tick(); tick();
    clear_ctrl();
    // Dirty every register first so the reset has something to clear.
    Bus2_Sel = BUS2_MEM; from_memory = 8'h22;
    IR_Load = 1'b1; MAR_Load = 1'b1; A_Load = 1'b1; B_Load = 1'b1; PC_Load = 1'b1;
    tick();
    clear_ctrl(); set_a(8'hFF); set_b(8'h01);
    alu_exec(ALU_ADD, 1'b1, "pre_reset_add", 8'h00, 4'b0101);
    clear_ctrl();
    Reset = 1'b1; IR_Load = 1'b1; MAR_Load = 1'b1; PC_Load = 1'b1; PC_Inc = 1'b1;
    A_Load = 1'b1; B_Load = 1'b1; CCR_Load = 1'b1; Bus2_Sel = BUS2_MEM; from_memory = 8'h5A;
    tick(); clear_ctrl(); #1;
    n_cmp++;
    if (IR !== 8'h00) begin n_err++; $display("FAIL reset IR: got %h expected 00", IR); end
    n_cmp++;
    if (address !== 8'h00) begin n_err++; $display("FAIL reset MAR: got %h expected 00", address); end
    n_cmp++;
    if (CCR_Result !== 4'b0000) begin n_err++; $display("FAIL reset CCR: got %b expected 0000", CCR_Result); end
    Bus1_Sel = BUS1_PC; #1;
    n_cmp++;
    if (to_memory !== 8'h00) begin n_err++; $display("FAIL reset PC: got %h expected 00", to_memory); end
    Bus1_Sel = BUS1_A; #1;
    n_cmp++;
    if (to_memory !== 8'h00) begin n_err++; $display("FAIL reset A: got %h expected 00", to_memory); end
    Bus1_Sel = BUS1_B; #1;
    n_cmp++;
    if (to_memory !== 8'h00) begin n_err++; $display("FAIL reset B: got %h expected 00", to_memory); end
    $display("txn reset IR=%h MAR=%h CCR=%b", IR, address, CCR_Result);
  endtask

  task automatic test_fetch();
    clear_ctrl(); set_pc(8'h00);
    Bus1_Sel = BUS1_PC; Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1;
    tick(); clear_ctrl();
    n_cmp++;
    if (address !== 8'h00) begin n_err++; $display("FAIL fetch MAR: got %h expected 00", address); end
    Bus2_Sel = BUS2_MEM; from_memory = 8'h01; IR_Load = 1'b1; PC_Inc = 1'b1; #1;
    n_cmp++;
    if (IR !== 8'h00) begin n_err++; $display("FAIL fetch IR before edge: got %h expected 00", IR); end
    tick(); clear_ctrl();
    n_cmp++;
    if (IR !== 8'h01) begin n_err++; $display("FAIL fetch IR: got %h expected 01", IR); end
    Bus1_Sel = BUS1_PC; #1;
    n_cmp++;
    if (to_memory !== 8'h01) begin n_err++; $display("FAIL fetch PC: got %h expected 01", to_memory); end
    Bus2_Sel = BUS2_BUS1; MAR_Load = 1'b1;
    tick(); clear_ctrl();
    n_cmp++;
    if (address !== 8'h01) begin n_err++; $display("FAIL fetch MAR<=PC: got %h expected 01", address); end
    $display("txn fetch IR=%h MAR=%h", IR, address);
  endtask

  task automatic test_add();
    set_a(8'hAA); set_b(8'h05);
    alu_exec(ALU_ADD, 1'b1, "add_aa_05", 8'hAF, 4'b1000);
    set_a(8'hFF); set_b(8'h01);
    alu_exec(ALU_ADD, 1'b1, "add_ff_01", 8'h00, 4'b0101);
    set_a(8'h7F); set_b(8'h01);
    alu_exec(ALU_ADD, 1'b1, "add_7f_01", 8'h80, 4'b1010);
  endtask

  task automatic test_sub();
    set_a(8'h80); set_b(8'h01);
    alu_exec(ALU_SUB, 1'b1, "sub_80_01", 8'h7F, 4'b0010);
    set_a(8'h05); set_b(8'h05);
    alu_exec(ALU_SUB, 1'b1, "sub_05_05", 8'h00, 4'b0100);
    set_a(8'h03); set_b(8'h05);
    alu_exec(ALU_SUB, 1'b1, "sub_03_05", 8'hFE, 4'b1001);
  endtask

  task automatic test_logic_ops();
    set_a(8'hF0); set_b(8'h3C);
    alu_exec(ALU_AND, 1'b1, "and_f0_3c", 8'h30, 4'b0000);
    set_a(8'hF0);
    alu_exec(ALU_OR, 1'b1, "or_f0_3c", 8'hFC, 4'b1000);
    set_a(8'h7F);
    alu_exec(ALU_INC, 1'b1, "inc_7f", 8'h80, 4'b1010);
    set_a(8'hFF);
    alu_exec(ALU_INC, 1'b1, "inc_ff", 8'h00, 4'b0101);
    set_a(8'h00);
    alu_exec(ALU_DEC, 1'b1, "dec_00", 8'hFF, 4'b1001);
    set_a(8'h80);
    alu_exec(ALU_DEC, 1'b1, "dec_80", 8'h7F, 4'b0010);
    set_a(8'h55);
    alu_exec(ALU_NOP6, 1'b1, "op_110", 8'h00, 4'b0000);
  endtask

  task automatic test_ccr_hold();
    set_a(8'hFF); set_b(8'h01);
    alu_exec(ALU_ADD, 1'b1, "hold_setup", 8'h00, 4'b0101);
    set_a(8'h80); set_b(8'h01);
    alu_exec(ALU_SUB, 1'b0, "sub_no_ccr", 8'h7F, 4'b0101);
  endtask

  task automatic test_branch();
    set_pc(8'h08);
    Bus2_Sel = BUS2_MEM; from_memory = 8'h80; PC_Load = 1'b1; PC_Inc = 1'b1;
    tick(); clear_ctrl();
    Bus1_Sel = BUS1_PC; #1;
    n_cmp++;
    if (to_memory !== 8'h80) begin n_err++; $display("FAIL branch PC: got %h expected 80", to_memory); end
    set_pc(8'hFF);
    PC_Inc = 1'b1; tick(); clear_ctrl();
    Bus1_Sel = BUS1_PC; #1;
    n_cmp++;
    if (to_memory !== 8'h00) begin n_err++; $display("FAIL pc_wrap PC: got %h expected 00", to_memory); end
    n_cmp++;
    if (CCR_Result !== 4'b0101) begin n_err++; $display("FAIL pc_wrap CCR: got %b expected 0101", CCR_Result); end
    $display("txn branch PC=%h CCR=%b", to_memory, CCR_Result);
  endtask

  task automatic test_store_path();
    set_a(8'hAF); set_b(8'h42);
    Bus1_Sel = BUS1_A; #1;
    n_cmp++;
    if (to_memory !== 8'hAF) begin n_err++; $display("FAIL store A: got %h expected AF", to_memory); end
    Bus1_Sel = BUS1_B; #1;
    n_cmp++;
    if (to_memory !== 8'h42) begin n_err++; $display("FAIL store B: got %h expected 42", to_memory); end
    Bus1_Sel = BUS1_ZERO; #1;
    n_cmp++;
    if (to_memory !== 8'h00) begin n_err++; $display("FAIL store zero: got %h expected 00", to_memory); end
    Bus2_Sel = BUS2_ZERO; IR_Load = 1'b1; tick(); clear_ctrl();
    n_cmp++;
    if (IR !== 8'h00) begin n_err++; $display("FAIL bus2_zero IR: got %h expected 00", IR); end
    $display("txn store_path IR=%h", IR);
  endtask

  task automatic test_multi_load();
    clear_ctrl();
    Bus2_Sel = BUS2_MEM; from_memory = 8'h3C;
    IR_Load = 1'b1; MAR_Load = 1'b1; A_Load = 1'b1; B_Load = 1'b1; PC_Load = 1'b1;
    tick(); clear_ctrl();
    n_cmp++;
    if (IR !== 8'h3C) begin n_err++; $display("FAIL multi IR: got %h expected 3C", IR); end
    n_cmp++;
    if (address !== 8'h3C) begin n_err++; $display("FAIL multi MAR: got %h expected 3C", address); end
    Bus1_Sel = BUS1_A; #1;
    n_cmp++;
    if (to_memory !== 8'h3C) begin n_err++; $display("FAIL multi A: got %h expected 3C", to_memory); end
    Bus1_Sel = BUS1_B; #1;
    n_cmp++;
    if (to_memory !== 8'h3C) begin n_err++; $display("FAIL multi B: got %h expected 3C", to_memory); end
    Bus1_Sel = BUS1_PC; #1;
    n_cmp++;
    if (to_memory !== 8'h3C) begin n_err++; $display("FAIL multi PC: got %h expected 3C", to_memory); end
    $display("txn multi_load IR=%h MAR=%h", IR, address);
  endtask

  initial begin
    clear_ctrl();
    Reset = 1'b1;
    test_reset();
    test_fetch();
    test_add();
    test_sub();
    test_logic_ops();
    test_ccr_hold();
    test_branch();
    test_store_path();
    test_multi_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
